// File: rtl/dllp_replay_ctrl.sv
// rtl/dllp_replay_ctrl.sv - DLL replay timer, Ack/Nak window check and replay/retrain sequencing
module dllp_replay_ctrl #(
  parameter int REPLAY_TIMEOUT = 711,
  parameter int SEQ_WIDTH      = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tlp_sent_i,
  input  logic [SEQ_WIDTH-1:0] tlp_seq_i,
  input  logic                 ack_nack_vld_i,
  input  logic                 ack_nack_i,
  input  logic [SEQ_WIDTH-1:0] ack_seq_num_i,
  input  logic                 replay_done_i,
  output logic                 replay_start_o,
  output logic                 replay_active_o,
  output logic                 retrain_req_o,
  output logic                 dllp_err_o,
  output logic [SEQ_WIDTH-1:0] acked_seq_o,
  output logic [SEQ_WIDTH-1:0] outstanding_o,
  output logic                 tlp_block_o
);

  localparam int TW = (REPLAY_TIMEOUT > 2) ? $clog2(REPLAY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(REPLAY_TIMEOUT - 1);
  localparam logic [SEQ_WIDTH-1:0] HALF_WIN = {1'b0, {(SEQ_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ARMED, REPLAY} state_t;

  state_t               state_q, state_d;
  logic [SEQ_WIDTH-1:0] last_sent_q, last_sent_d;
  logic [SEQ_WIDTH-1:0] acked_q, acked_d;
  logic [1:0]           replay_num_q, replay_num_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 replay_start_q, replay_start_d;
  logic                 retrain_q, retrain_d;
  logic                 dllp_err_q, dllp_err_d;

  logic [SEQ_WIDTH-1:0] outstanding;
  logic [SEQ_WIDTH-1:0] ack_dist;
  logic [SEQ_WIDTH-1:0] new_out;
  logic                 ack_accept;
  logic                 ack_fwd;
  logic                 timeout;
  logic                 nak_replay;

  assign outstanding = last_sent_q - acked_q;
  assign ack_dist    = ack_seq_num_i - acked_q;

  always_comb begin
    state_d        = state_q;
    last_sent_d    = last_sent_q;
    acked_d        = acked_q;
    replay_num_d   = replay_num_q;
    timer_d        = timer_q;
    replay_start_d = 1'b0;
    retrain_d      = 1'b0;
    timeout        = 1'b0;
    nak_replay     = 1'b0;

    // An Ack/Nak is only meaningful if it lands inside the unacknowledged window
    ack_accept = ack_nack_vld_i && (ack_dist <= outstanding);
    ack_fwd    = ack_accept && (ack_dist != '0);
    dllp_err_d = ack_nack_vld_i && !ack_accept;

    if (tlp_sent_i && state_q != REPLAY) begin
      last_sent_d = tlp_seq_i;
    end
    if (ack_fwd) begin
      acked_d      = ack_seq_num_i;
      replay_num_d = 2'd0;
    end
    new_out = last_sent_d - acked_d;

    case (state_q)
      IDLE, ARMED: begin
        timeout    = (state_q == ARMED) && (timer_q == TIMER_LAST) && !ack_fwd;
        nak_replay = ack_accept && !ack_nack_i && (new_out != '0);
        if (timeout || nak_replay) begin
          state_d        = REPLAY;
          timer_d        = '0;
          replay_start_d = 1'b1;
          retrain_d      = (replay_num_d == 2'd3);
          replay_num_d   = replay_num_d + 2'd1;
        end else if (new_out == '0) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          state_d = ARMED;
          // A fresh ARMED entry or forward progress restarts the timer; new TLPs do not
          if (state_q == IDLE || ack_fwd) begin
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      REPLAY: begin
        timer_d = '0;
        if (replay_done_i) begin
          state_d = (new_out != '0) ? ARMED : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      last_sent_q    <= '1;
      acked_q        <= '1;
      replay_num_q   <= 2'd0;
      timer_q        <= '0;
      replay_start_q <= 1'b0;
      retrain_q      <= 1'b0;
      dllp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_sent_q    <= last_sent_d;
      acked_q        <= acked_d;
      replay_num_q   <= replay_num_d;
      timer_q        <= timer_d;
      replay_start_q <= replay_start_d;
      retrain_q      <= retrain_d;
      dllp_err_q     <= dllp_err_d;
    end
  end

  assign replay_start_o  = replay_start_q;
  assign retrain_req_o   = retrain_q;
  assign dllp_err_o      = dllp_err_q;
  assign replay_active_o = (state_q == REPLAY);
  assign acked_seq_o     = acked_q;
  assign outstanding_o   = outstanding;
  assign tlp_block_o     = (state_q == REPLAY) || (outstanding >= HALF_WIN);

endmodule
